// File: rtl/sar_adc12_ctrl.sv
// 12-bit successive-approximation ADC controller: one DAC trial per bit, held
// SETTLE_CYCLES cycles before the synchronized comparator decides that bit.
module sar_adc12_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        cmp_in,
  output logic [11:0] dac_code,
  output logic        busy,
  output logic [11:0] result,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  idx;
  logic        cmp_meta;
  logic        cmp_s;
  logic [11:0] decided_code;

  // NOTE: default assignment first so every path writes decided_code; no latch.
  always_comb begin
    decided_code = dac_code;
    if (!cmp_s) decided_code[idx] = 1'b0;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      idx      <= 4'd11;
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
      dac_code <= 12'h000;
      busy     <= 1'b0;
      result   <= 12'h000;
      done     <= 1'b0;
    end else begin
      cmp_meta <= cmp_in;
      cmp_s    <= cmp_meta;
      done     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= SETTLE;
            idx      <= 4'd11;
            cnt      <= 8'd0;
            dac_code <= 12'h800;
            busy     <= 1'b1;
          end
        end

        SETTLE: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            dac_code <= 12'h000;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(SETTLE_CYCLES - 1)) state <= DECIDE;
          end
        end

        DECIDE: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            dac_code <= 12'h000;
          end else if (idx == 4'd0) begin
            // Final bit: the decided code becomes the result and stays on the DAC.
            state    <= IDLE;
            busy     <= 1'b0;
            dac_code <= decided_code;
            result   <= decided_code;
            done     <= 1'b1;
          end else begin
            state    <= SETTLE;
            idx      <= idx - 4'd1;
            cnt      <= 8'd0;
            dac_code <= decided_code | (12'h001 << (idx - 4'd1));
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          dac_code <= 12'h000;
        end
      endcase
    end
  end

endmodule

// File: doc/sar_adc12_ctrl.md
SAR_ADC12_CTRL -- requirements
Module: sar_adc12_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles the DAC code is held before the comparator is sampled; legal range 3..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancel conversion in progress.
REQ-006 SHALL have port cmp_in  input  1  asynchronous comparator output; 1 = analog input >= DAC output.
REQ-007 SHALL have port dac_code  output  12  trial code driven to the 12-bit DAC.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port result  output  12  last completed conversion, held until the next completion.
REQ-010 SHALL have port done  output  1  one-cycle pulse, high in the cycle result first shows a new value.

Function
REQ-011 SHALL pass cmp_in through a 2-flop synchronizer (cmp_s); only cmp_s is used by the FSM.
REQ-012 SHALL implement states IDLE, SETTLE and DECIDE; busy = 1 in SETTLE and DECIDE, 0 in IDLE.
REQ-013 IDLE with start=1, abort=0: next cycle bit index = 11, dac_code = 0x800, settle counter = 0, state SETTLE.
REQ-014 SETTLE: counter increments each cycle; after exactly SETTLE_CYCLES cycles in SETTLE -> DECIDE.
REQ-015 DECIDE: if cmp_s = 0, clear dac_code[index]; if cmp_s = 1, keep it.
REQ-016 DECIDE with index > 0: decrement index, set dac_code[index-1] = 1, counter = 0, -> SETTLE.
REQ-017 DECIDE with index = 0: result <= final code (with bit 0 decided this cycle), done = 1 for one cycle, -> IDLE.
REQ-018 In IDLE after a completed conversion, dac_code SHALL hold the final result code.
REQ-019 Latency: start accepted at edge k -> done high and result valid after edge k + 12*(SETTLE_CYCLES+1).
REQ-020 start while busy SHALL be ignored: no restart and no effect on the current conversion.
REQ-021 abort = 1 in SETTLE or DECIDE: next cycle state IDLE, busy = 0, dac_code = 0x000, done = 0, result unchanged.
REQ-022 start and abort both high in IDLE: abort wins; no conversion starts.
REQ-023 abort in the final DECIDE cycle: abort wins; no done pulse; result unchanged.
REQ-024 start high on the cycle after done (IDLE): new conversion accepted normally; back-to-back conversions allowed.
REQ-025 done SHALL never be high for more than one consecutive cycle.

Reset
REQ-026 rst = 1 at any edge: state IDLE, busy = 0, done = 0, dac_code = 0x000, result = 0x000, counter = 0, index = 11, both synchronizer flops = 0.
REQ-027 rst SHALL take priority over start and abort; reset mid-conversion discards the partial conversion with no done pulse.
REQ-028 start SHALL be ignored on any cycle where rst = 1; the first start can be accepted on the first cycle with rst = 0.

Verification
REQ-029 Bench comparator model cmp_in = (vin >= dac_code), SETTLE_CYCLES = 4, vin = 0xABC, pulse start -> done exactly 60 cycles later, result = 0xABC, dac_code = 0xABC.
REQ-030 vin = 0x000 -> result 0x000; vin = 0xFFF -> result 0xFFF; vin = 0x800 -> result 0x800; each with busy high for exactly 60 cycles.
REQ-031 vin = 0x123, re-pulse start at cycle 20 of the conversion -> ignored, single done at cycle 60, result = 0x123.
REQ-032 Complete a conversion with vin = 0x555, then abort at cycle 30 of a conversion with vin = 0x3C0 -> busy low next cycle, dac_code = 0x000, no done, result stays 0x555.
REQ-033 Assert rst at cycle 25 of a conversion -> all outputs at reset values next cycle, no done; a new start with vin = 0x7FF -> result 0x7FF.
REQ-034 SETTLE_CYCLES = 3, two back-to-back conversions (vin 0x001, then 0xFFE, start on the cycle after done) -> done 48 cycles after each accepted start, results 0x001 and 0xFFE.
